// File: rtl/adder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : adder_rr_arbiter
//  Purpose  : Round-robin sharing of one start/valid adder among N requesters,
//             with a watchdog that turns a missing adder valid into an error.
//  Revision : 1.0 - initial release
// ============================================================================
module adder_rr_arbiter #(
    parameter int W       = 10,
    parameter int N       = 4,
    parameter int TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       req_a,
    input  logic [N*W-1:0]       req_b,
    output logic [N-1:0]         gnt,
    output logic                 add_start,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    input  logic [W-1:0]         add_y,
    input  logic                 add_valid,
    output logic                 rsp_valid,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic [W-1:0]         rsp_y,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 spurious_err
);

    localparam int ID_W  = $clog2(N);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    localparam logic [ID_W-1:0]  c_LAST_MAX  = ID_W'(N - 1);
    localparam logic [ID_W-1:0]  c_ID_ONE    = ID_W'(1);
    localparam logic [ID_W:0]    c_N_EXT     = (ID_W + 1)'(N);
    localparam logic [N-1:0]     c_GNT_ONE   = N'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_LIMIT = CNT_W'(TIMEOUT);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;

    logic [ID_W-1:0]  r_last;
    logic [ID_W-1:0]  r_id;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_add_a;
    logic [W-1:0]     r_add_b;
    logic [W-1:0]     r_rsp_y;
    logic             r_rsp_err;
    logic             r_spur;

    logic             w_any_req;
    logic [ID_W-1:0]  w_start;
    logic [N-1:0]     w_req_rot;
    logic [ID_W-1:0]  w_ofs;
    logic [ID_W:0]    w_sum;
    logic [ID_W-1:0]  w_winner;
    logic [W-1:0]     w_sel_a;
    logic [W-1:0]     w_sel_b;
    logic             w_timeout;

    logic [N-1:0]     w_gnt;
    logic             w_add_start;
    logic             w_rsp_valid;
    logic             w_busy;

    // ------------------------------------------------------------------
    // Round-robin winner: rotate req so bit 0 is the slot after the last
    // grant, take the lowest set bit, then rotate the offset back.
    // ------------------------------------------------------------------
    assign w_any_req = |req;
    assign w_start   = (r_last == c_LAST_MAX) ? '0 : (r_last + c_ID_ONE);
    assign w_req_rot = N'({req, req} >> w_start);

    always_comb begin
        w_ofs = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_ofs = ID_W'(i);
            end
        end
    end

    assign w_sum    = {1'b0, w_start} + {1'b0, w_ofs};
    assign w_winner = (w_sum >= c_N_EXT) ? ID_W'(w_sum - c_N_EXT) : w_sum[ID_W-1:0];

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_sel_a = req_a[i*W +: W];
                w_sel_b = req_b[i*W +: W];
            end
        end
    end

    assign w_timeout = (r_cnt == c_CNT_LIMIT);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_any_req) begin
                    w_state_next = c_ISSUE;
                end
            end
            c_ISSUE: begin
                w_state_next = c_WAIT;
            end
            c_WAIT: begin
                if (add_valid || w_timeout) begin
                    w_state_next = c_RESP;
                end
            end
            c_RESP: begin
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Pulses are masked while rst is high so an in-flight
    // operation never leaks a grant, start or response during reset.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt       = '0;
        w_add_start = 1'b0;
        w_rsp_valid = 1'b0;
        w_busy      = (r_state != c_IDLE);
        case (r_state)
            c_IDLE: begin
                if (w_any_req && !rst) begin
                    w_gnt = c_GNT_ONE << w_winner;
                end
            end
            c_ISSUE: begin
                w_add_start = !rst;
            end
            c_RESP: begin
                w_rsp_valid = !rst;
            end
            default: begin
                w_gnt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last    <= c_LAST_MAX;
            r_id      <= '0;
            r_cnt     <= '0;
            r_add_a   <= '0;
            r_add_b   <= '0;
            r_rsp_y   <= '0;
            r_rsp_err <= 1'b0;
            r_spur    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_add_a <= w_sel_a;
                        r_add_b <= w_sel_b;
                        r_id    <= w_winner;
                        r_last  <= w_winner;
                    end
                end
                c_ISSUE: begin
                    r_cnt <= '0;
                end
                c_WAIT: begin
                    if (add_valid) begin
                        r_rsp_y   <= add_y;
                        r_rsp_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_y   <= '0;
                        r_rsp_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
            // A valid that arrives when nothing is outstanding is flagged, never used
            if (add_valid && (r_state != c_WAIT)) begin
                r_spur <= 1'b1;
            end
        end
    end

    assign gnt          = w_gnt;
    assign add_start    = w_add_start;
    assign add_a        = r_add_a;
    assign add_b        = r_add_b;
    assign rsp_valid    = w_rsp_valid;
    assign rsp_id       = r_id;
    assign rsp_y        = r_rsp_y;
    assign rsp_err      = r_rsp_err;
    assign busy         = w_busy;
    assign spurious_err = r_spur;

`ifndef SYNTHESIS
    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_pulses_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(((|gnt) && add_start) || ((|gnt) && rsp_valid) || (add_start && rsp_valid)));
    a_rsp_single: assert property (@(posedge clk) disable iff (rst) rsp_valid |=> !rsp_valid);
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_rr_arbiter
//  Purpose  : Scoreboard bench for adder_rr_arbiter with a 1-cycle adder stub.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_rr_arbiter;

    localparam int W   = 10;
    localparam int N   = 4;
    localparam int T   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   gnt;
    logic           add_start;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W-1:0]   add_y = '0;
    logic           add_valid;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_y;
    logic           rsp_err;
    logic           busy;
    logic           spurious_err;

    logic m_valid  = 1'b0;
    logic inj      = 1'b0;
    logic suppress = 1'b0;
    assign add_valid = m_valid | inj;

    adder_rr_arbiter #(.W(W), .N(N), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_y(add_y), .add_valid(add_valid), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy),
        .spurious_err(spurious_err)
    );

    always #5 clk = ~clk;

    // Adder stub: one-cycle latency, valid withheld while suppress is set
    always @(posedge clk) begin
        m_valid <= add_start && !suppress;
        add_y   <= add_a + add_b;
    end

    typedef struct {
        int id;
        int y;
        int err;
    } exp_t;

    exp_t         sb[$];
    int           gnt_log[$];
    int           checks = 0;
    int           failures = 0;
    int           n_grants = 0;
    int           cyc = 0;
    bit           active = 1'b0;
    int           gnt_cyc = 0;
    int           rsp_cyc = 0;
    int           model_last = N - 1;
    int           exp_a = 0;
    int           exp_b = 0;
    bit           spur_model = 1'b0;
    bit           rst_seen = 1'b0;
    bit           refill = 1'b0;
    logic [N-1:0] granted_last = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // First asserted requester after 'last', scanning upward with wrap
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // ------------------------------------------------------------------
    // Monitor / reference model, sampled on the falling edge
    // ------------------------------------------------------------------
    bit   idle_exp, busy_exp, wait_exp, start_exp, rsp_exp;
    int   win;
    exp_t e;

    always @(negedge clk) begin
        busy_exp = active && (cyc > gnt_cyc) && (cyc <= rsp_cyc);
        wait_exp = active && (cyc >= gnt_cyc + 2) && (cyc < rsp_cyc);
        idle_exp = !active || (cyc > rsp_cyc);
        chk("spurious_err", spurious_err, spur_model);
        if (rst_seen) begin
            chk("rst_add_a", add_a, 0);
            chk("rst_add_b", add_b, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_y", rsp_y, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_busy", busy, 0);
        end
        if (rst) begin
            chk("rst_gnt", gnt, 0);
            chk("rst_add_start", add_start, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            sb.delete();
            active     = 1'b0;
            model_last = N - 1;
        end else begin
            chk("busy", busy, busy_exp);
            if ((gnt != '0) || (idle_exp && (req != '0))) begin
                chk("gnt_while_busy", idle_exp, 1);
                win = rr_pick(req, model_last);
                chk("gnt", gnt, (win < 0) ? 0 : (1 << win));
                if (win >= 0 && idle_exp) begin
                    exp_a = int'(req_a[win*W +: W]);
                    exp_b = int'(req_b[win*W +: W]);
                    e.id  = win;
                    e.y   = suppress ? 0 : (exp_a + exp_b) % (1 << W);
                    e.err = suppress ? 1 : 0;
                    sb.push_back(e);
                    active     = 1'b1;
                    gnt_cyc    = cyc;
                    rsp_cyc    = cyc + 3 + (suppress ? T : 0);
                    model_last = win;
                    gnt_log.push_back(win);
                    n_grants++;
                end
            end
            start_exp = active && (cyc == gnt_cyc + 1);
            chk("add_start", add_start, start_exp);
            if (start_exp) begin
                chk("add_a", add_a, exp_a);
                chk("add_b", add_b, exp_b);
            end
            rsp_exp = active && (cyc == rsp_cyc);
            chk("rsp_valid", rsp_valid, rsp_exp);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_y", rsp_y, e.y);
                    chk("rsp_err", rsp_err, e.err);
                end
            end
        end
        spur_model   = rst ? 1'b0 : (spur_model | (add_valid && !wait_exp));
        granted_last = rst ? '0 : gnt;
        rst_seen     = rst;
        cyc++;
    end

    // ------------------------------------------------------------------
    // Requester side
    // ------------------------------------------------------------------
    task automatic set_req(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
        req[i]          = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (granted_last[i]) begin
                if (refill) begin
                    req_a[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
                    req_b[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
                end else begin
                    req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (((req != '0) || (sb.size() != 0)) && (n < budget)) begin
            step();
            n++;
        end
        if (n >= budget) begin
            chk("wait_idle_budget", sb.size() + int'(req), 0);
        end
        step();
    endtask

    int g0;
    int nw;
    int fair_exp[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        repeat (3) step();
        rst = 1'b0;

        set_req(2, 300, 200);
        wait_idle(50);
        set_req(1, 1000, 100);
        wait_idle(50);

        suppress = 1'b1;
        set_req(3, 5, 6);
        wait_idle(60);
        suppress = 1'b0;
        set_req(0, 1023, 1);
        wait_idle(50);

        // Reset while the adder is stalled in WAIT
        suppress = 1'b1;
        g0 = n_grants;
        set_req(1, 7, 8);
        nw = 0;
        while ((n_grants == g0) && (nw < 20)) begin
            step();
            nw++;
        end
        repeat (3) step();
        set_req(0, 11, 22);
        set_req(2, 33, 44);
        rst = 1'b1;
        gnt_log.delete();
        repeat (3) step();
        suppress = 1'b0;
        rst = 1'b0;
        wait_idle(80);
        chk("post_rst_grants", gnt_log.size(), 2);
        if (gnt_log.size() > 0) chk("post_rst_first_gnt", gnt_log[0], 0);

        inj = 1'b1;
        step();
        inj = 1'b0;
        repeat (4) step();
        set_req(3, 511, 512);
        wait_idle(50);
        chk("spurious_sticky", spurious_err, 1);

        // Fairness: all requesters held continuously from reset
        rst = 1'b1;
        repeat (2) step();
        gnt_log.delete();
        refill = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, 1023), $urandom_range(0, 1023));
        rst = 1'b0;
        nw = 0;
        while ((gnt_log.size() < 6) && (nw < 60)) begin
            step();
            nw++;
        end
        refill = 1'b0;
        wait_idle(80);
        chk("fair_count", (gnt_log.size() >= 6) ? 1 : 0, 1);
        for (int k = 0; k < 6; k++) begin
            if (k < gnt_log.size()) chk("fair_order", gnt_log[k], fair_exp[k]);
        end

        // Random traffic, including requests withdrawn before grant
        repeat (300) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!req[i] && ($urandom_range(0, 3) == 0)) begin
                    set_req(i, $urandom_range(0, 1023), $urandom_range(0, 1023));
                end else if (req[i] && ($urandom_range(0, 19) == 0)) begin
                    req[i] = 1'b0;
                end
            end
        end
        wait_idle(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
